// File: rtl/cache_mem_ctrl_if.sv
// Bus bundle between the data cache / main memory side and cache_mem_ctrl.
//   slave  : used by cache_mem_ctrl. It takes refill and write-back requests from the cache,
//            drives the memory request bus, and returns refills.
//   master : used by the cache/memory environment that drives requests and memory responses.
// Signals:
//   miss_req/miss_addr/miss_ready           refill request handshake
//   wb_req/wb_addr/wb_data/wb_ready         write-back handshake
//   fill_valid/fill_addr/fill_data          one-cycle refill return strobe
//   mem_req/mem_we/mem_addr/mem_wdata       memory request, held until mem_ack
//   mem_ack/mem_rdata                       memory completion and read data
//   wb_overflow                             sticky dropped-write-back flag
interface cache_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
) ();
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_overflow;

  modport slave (
    input  miss_req, miss_addr, wb_req, wb_addr, wb_data, mem_ack, mem_rdata,
    output miss_ready, wb_ready, fill_valid, fill_addr, fill_data,
    output mem_req, mem_we, mem_addr, mem_wdata, wb_overflow
  );

  modport master (
    output miss_req, miss_addr, wb_req, wb_addr, wb_data, mem_ack, mem_rdata,
    input  miss_ready, wb_ready, fill_valid, fill_addr, fill_data,
    input  mem_req, mem_we, mem_addr, mem_wdata, wb_overflow
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Cache-to-memory controller sitting below the 2-way data cache.
// Holds one outstanding refill and a small write-back FIFO. Reads take priority over
// queued write-backs, and a refill that hits in the FIFO is served from the youngest
// matching entry without touching memory.
// Ports:
//   clk    clock, all state on rising edge
//   reset  synchronous active-high reset
//   bus    cache_mem_ctrl_if.slave: cache request/fill signals and memory request bus
module cache_mem_ctrl #(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WB_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  cache_mem_ctrl_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {StIdle, StRdReq, StWrReq, StFill} state_e;

  state_e              state_q, state_d;
  logic                rd_pend_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic                overflow_q;

  logic [ADDR_W-1:0]   fifo_addr_q [WB_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [WB_DEPTH];
  // Extra MSB distinguishes full from empty when the index bits are equal.
  logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count;
  logic [PTR_W-1:0]    head_idx, scan_idx;
  logic                full, empty, push, pop, miss_acc, clear_pend;
  logic                hit;
  logic [DATA_W-1:0]   hit_data;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_idx = rd_ptr_q[PTR_W-1:0];

  // Full is taken from registered pointers, so a pop in the same cycle does not make room.
  assign push     = bus.wb_req && !full && !reset;
  assign miss_acc = bus.miss_req && !rd_pend_q;

  // Scan oldest to youngest so the last match (youngest entry) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      scan_idx = head_idx + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (fifo_addr_q[scan_idx] == rd_addr_q)) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[scan_idx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_data_d = fill_data_q;
    pop         = 1'b0;
    clear_pend  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_pend_q && hit) begin
          state_d     = StFill;
          fill_data_d = hit_data;
        end else if (rd_pend_q) begin
          state_d = StRdReq;
        end else if (!empty) begin
          state_d = StWrReq;
        end
      end
      StRdReq: begin
        if (bus.mem_ack) begin
          fill_data_d = bus.mem_rdata;
          state_d     = StFill;
        end
      end
      StWrReq: begin
        if (bus.mem_ack) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      StFill: begin
        clear_pend = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      fill_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_data_q <= fill_data_d;
      if (miss_acc) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= bus.miss_addr;
      end else if (clear_pend) begin
        rd_pend_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      if (bus.wb_req && full) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset; pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= bus.wb_addr;
      fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= bus.wb_data;
    end
  end

  assign bus.miss_ready  = !rd_pend_q;
  assign bus.wb_ready    = !full;
  assign bus.fill_valid  = (state_q == StFill);
  assign bus.fill_addr   = rd_addr_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.mem_req     = (state_q == StRdReq) || (state_q == StWrReq);
  assign bus.mem_we      = (state_q == StWrReq);
  assign bus.mem_addr    = (state_q == StRdReq) ? rd_addr_q :
                           (state_q == StWrReq) ? fifo_addr_q[head_idx] : '0;
  assign bus.mem_wdata   = (state_q == StWrReq) ? fifo_data_q[head_idx] : '0;
  assign bus.wb_overflow = overflow_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: a per-cycle vector table for the basic refill and
// forwarding paths, then hand-written sequences for the multi-cycle cases.
module tb_cache_mem_ctrl;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WB_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: manual ack, or auto-ack every request with address-derived read data.
  logic          man_ack = 1'b0;
  logic [DW-1:0] man_rdata = '0;
  logic          auto_en = 1'b0;
  assign bus.mem_ack   = auto_en ? bus.mem_req : man_ack;
  assign bus.mem_rdata = auto_en ? (32'(bus.mem_addr) ^ 32'h5A5A_0000) : man_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;
  op_t           log_q[$];
  int            fill_cnt = 0;
  logic [AW-1:0] last_fill_addr = '0;
  logic [DW-1:0] last_fill_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_ack)
        log_q.push_back('{bus.mem_we, bus.mem_addr,
                          bus.mem_we ? bus.mem_wdata : bus.mem_rdata});
      if (bus.fill_valid) begin
        fill_cnt++;
        last_fill_addr = bus.fill_addr;
        last_fill_data = bus.fill_data;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_op(input string name, input int idx, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (idx < log_q.size()) begin
      check({name, ".we"}, 64'(log_q[idx].we), 64'(we));
      check({name, ".addr"}, 64'(log_q[idx].addr), 64'(addr));
      check({name, ".data"}, 64'(log_q[idx].data), 64'(data));
    end else begin
      check({name, ".present"}, 64'(log_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.wb_req    = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    man_ack       = 1'b0;
    man_rdata     = '0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 60 && log_q.size() < n; i++) step();
  endtask

  task automatic wait_fill(input int n);
    for (int i = 0; i < 60 && fill_cnt < n; i++) step();
  endtask

  function automatic int reads_from(input int base);
    int n = 0;
    for (int i = base; i < log_q.size(); i++) if (!log_q[i].we) n++;
    return n;
  endfunction

  // Expected flags: {miss_ready, wb_ready, fill_valid, mem_req, mem_we}.
  // e_addr/e_data are fill_addr/fill_data when fill_valid, else mem_addr/mem_wdata.
  typedef struct {
    logic          mr;
    logic [AW-1:0] ma;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ak;
    logic [DW-1:0] rd;
    logic [4:0]    ef;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic mr, input logic [AW-1:0] ma, input logic wr,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic ak,
                     input logic [DW-1:0] rd, input logic [4:0] ef,
                     input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data);
    vecs.push_back('{mr, ma, wr, wa, wd, ak, rd, ef, e_addr, e_data});
  endtask

  initial begin
    int base;
    int fbase;
    string nm;
    idle_in();
    // Refill from memory, ack three cycles after mem_req, then forwarding hit + drain.
    add(0, 0,     0, 0,    0,            0, 0,            5'b11000, 0,     0);
    add(1, 'h100, 0, 0,    0,            0, 0,            5'b11000, 0,     0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b01000, 0,     0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b01010, 'h100, 0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b01010, 'h100, 0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b01010, 'h100, 0);
    add(0, 0,     0, 0,    0,            1, 32'hDEADBEEF, 5'b01010, 'h100, 0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b01100, 'h100, 32'hDEADBEEF);
    add(0, 0,     0, 0,    0,            0, 0,            5'b11000, 0,     0);
    add(1, 'h20,  1, 'h20, 32'h22222222, 0, 0,            5'b11000, 0,     0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b01000, 0,     0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b01100, 'h20,  32'h22222222);
    add(0, 0,     0, 0,    0,            0, 0,            5'b11000, 0,     0);
    add(0, 0,     0, 0,    0,            1, 0,            5'b11011, 'h20,  32'h22222222);
    add(0, 0,     0, 0,    0,            0, 0,            5'b11000, 0,     0);
    add(0, 0,     0, 0,    0,            0, 0,            5'b11000, 0,     0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[k]) begin
      bus.miss_req  = vecs[k].mr;
      bus.miss_addr = vecs[k].ma;
      bus.wb_req    = vecs[k].wr;
      bus.wb_addr   = vecs[k].wa;
      bus.wb_data   = vecs[k].wd;
      man_ack       = vecs[k].ak;
      man_rdata     = vecs[k].rd;
      @(negedge clk);
      nm = $sformatf("vec%0d", k);
      check({nm, ".miss_ready"}, 64'(bus.miss_ready), 64'(vecs[k].ef[4]));
      check({nm, ".wb_ready"}, 64'(bus.wb_ready), 64'(vecs[k].ef[3]));
      check({nm, ".fill_valid"}, 64'(bus.fill_valid), 64'(vecs[k].ef[2]));
      check({nm, ".mem_req"}, 64'(bus.mem_req), 64'(vecs[k].ef[1]));
      check({nm, ".wb_overflow"}, 64'(bus.wb_overflow), 64'(0));
      if (vecs[k].ef[2]) begin
        check({nm, ".fill_addr"}, 64'(bus.fill_addr), 64'(vecs[k].e_addr));
        check({nm, ".fill_data"}, 64'(bus.fill_data), 64'(vecs[k].e_data));
      end
      if (vecs[k].ef[1]) begin
        check({nm, ".mem_we"}, 64'(bus.mem_we), 64'(vecs[k].ef[0]));
        check({nm, ".mem_addr"}, 64'(bus.mem_addr), 64'(vecs[k].e_addr));
        if (vecs[k].ef[0]) check({nm, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(vecs[k].e_data));
      end
      step();
    end
    idle_in();
    check("tbl.ops", 64'(log_q.size()), 64'(2));
    check_op("tbl.op0", 0, 1'b0, 'h100, 32'hDEADBEEF);
    check_op("tbl.op1", 1, 1'b1, 'h20, 32'h22222222);

    // Miss arrives while a write waits; the write finishes, then the read, then the rest.
    base = log_q.size();
    fbase = fill_cnt;
    bus.wb_req = 1; bus.wb_addr = 'h31; bus.wb_data = 'h1111; step();
    bus.wb_addr = 'h32; bus.wb_data = 'h2222; step();
    bus.wb_addr = 'h33; bus.wb_data = 'h3333; step();
    bus.wb_req = 0; bus.miss_req = 1; bus.miss_addr = 'h300; step();
    bus.miss_req = 0;
    @(negedge clk);
    check("prio.inflight_we", 64'(bus.mem_we), 64'(1));
    check("prio.inflight_addr", 64'(bus.mem_addr), 64'('h31));
    check("prio.miss_ready", 64'(bus.miss_ready), 64'(0));
    step();
    auto_en = 1;
    wait_log(base + 4);
    repeat (5) step();
    auto_en = 0;
    check("prio.ops", 64'(log_q.size()), 64'(base + 4));
    check_op("prio.op0", base, 1'b1, 'h31, 'h1111);
    check_op("prio.op1", base + 1, 1'b0, 'h300, 32'h5A5A_0300);
    check_op("prio.op2", base + 2, 1'b1, 'h32, 'h2222);
    check_op("prio.op3", base + 3, 1'b1, 'h33, 'h3333);
    check("prio.fills", 64'(fill_cnt), 64'(fbase + 1));
    check("prio.fill_addr", 64'(last_fill_addr), 64'('h300));
    check("prio.fill_data", 64'(last_fill_data), 64'(32'h5A5A_0300));

    // Stalled memory fills the FIFO; a 5th push alongside a pop is still dropped.
    base = log_q.size();
    for (int i = 0; i < 4; i++) begin
      bus.wb_req = 1; bus.wb_addr = AW'('h41 + i); bus.wb_data = DW'('h4000 + i); step();
    end
    bus.wb_req = 0;
    @(negedge clk);
    check("full.wb_ready", 64'(bus.wb_ready), 64'(0));
    check("full.ovf_before", 64'(bus.wb_overflow), 64'(0));
    step();
    bus.wb_req = 1; bus.wb_addr = 'h45; bus.wb_data = 'h4005; man_ack = 1;
    step();
    bus.wb_req = 0; man_ack = 0;
    @(negedge clk);
    check("full.ovf", 64'(bus.wb_overflow), 64'(1));
    check("full.wb_ready_after_pop", 64'(bus.wb_ready), 64'(1));
    step();
    auto_en = 1;
    wait_log(base + 4);
    repeat (8) step();
    auto_en = 0;
    check("full.ops", 64'(log_q.size()), 64'(base + 4));
    for (int i = 0; i < 4; i++)
      check_op($sformatf("full.op%0d", i), base + i, 1'b1, AW'('h41 + i), DW'('h4000 + i));
    check("full.ovf_sticky", 64'(bus.wb_overflow), 64'(1));

    // Two queued writes to one address behind a stalled write: refill takes the younger.
    base = log_q.size();
    fbase = fill_cnt;
    bus.wb_req = 1; bus.wb_addr = 'h50; bus.wb_data = 'h5; step();
    bus.wb_addr = 'h40; bus.wb_data = 'hA; step();
    bus.wb_addr = 'h40; bus.wb_data = 'hB; step();
    bus.wb_req = 0; bus.miss_req = 1; bus.miss_addr = 'h40; step();
    bus.miss_req = 0;
    @(negedge clk);
    check("fwd.stalled_addr", 64'(bus.mem_addr), 64'('h50));
    check("fwd.stalled_we", 64'(bus.mem_we), 64'(1));
    step();
    man_ack = 1; step();
    man_ack = 0;
    wait_fill(fbase + 1);
    check("fwd.fills", 64'(fill_cnt), 64'(fbase + 1));
    check("fwd.fill_addr", 64'(last_fill_addr), 64'('h40));
    check("fwd.fill_data", 64'(last_fill_data), 64'('hB));
    auto_en = 1;
    wait_log(base + 3);
    repeat (4) step();
    auto_en = 0;
    check("fwd.ops", 64'(log_q.size()), 64'(base + 3));
    check("fwd.no_read", 64'(reads_from(base)), 64'(0));
    check_op("fwd.op0", base, 1'b1, 'h50, 'h5);
    check_op("fwd.op1", base + 1, 1'b1, 'h40, 'hA);
    check_op("fwd.op2", base + 2, 1'b1, 'h40, 'hB);

    // Reset during an outstanding read with a write queued; a late ack must do nothing.
    base = log_q.size();
    fbase = fill_cnt;
    bus.miss_req = 1; bus.miss_addr = 'h700; step();
    bus.miss_req = 0; bus.wb_req = 1; bus.wb_addr = 'h77; bus.wb_data = 'h7777; step();
    bus.wb_req = 0;
    for (int i = 0; i < 10 && !bus.mem_req; i++) step();
    @(negedge clk);
    check("rst.pre_req", 64'(bus.mem_req), 64'(1));
    check("rst.pre_addr", 64'(bus.mem_addr), 64'('h700));
    step();
    reset = 1; step();
    reset = 0;
    @(negedge clk);
    check("rst.mem_req", 64'(bus.mem_req), 64'(0));
    check("rst.miss_ready", 64'(bus.miss_ready), 64'(1));
    check("rst.wb_ready", 64'(bus.wb_ready), 64'(1));
    check("rst.ovf_cleared", 64'(bus.wb_overflow), 64'(0));
    step();
    man_ack = 1; man_rdata = 32'hBAD0BAD0; step();
    man_ack = 0;
    repeat (6) step();
    check("rst.no_fill", 64'(fill_cnt), 64'(fbase));
    auto_en = 1;
    repeat (8) step();
    auto_en = 0;
    check("rst.fifo_emptied", 64'(log_q.size()), 64'(base));
    check("rst.idle_req", 64'(bus.mem_req), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
